// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: decoder FSM states
// and the constants common to the LFSR-based number generators.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sc_state_t;

  localparam int SC_LFSR_PERIOD = 255;
  localparam int SC_CW          = 8;

endpackage

// File: rtl/sc_ones_counter.sv
// Counter pair for one decoding window: valid bits consumed and ones seen.
// Clear has priority over enable.
module sc_ones_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic          i_bit,
  output logic [CW-1:0] o_bits_seen,
  output logic [CW-1:0] o_ones
);

  logic [CW-1:0] r_bits_seen;
  logic [CW-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits_seen <= '0;
      r_ones      <= '0;
    end else if (i_clear) begin
      r_bits_seen <= '0;
      r_ones      <= '0;
    end else if (i_enable) begin
      r_bits_seen <= r_bits_seen + CW'(1);
      r_ones      <= r_ones + CW'(i_bit);
    end
  end

  assign o_bits_seen = r_bits_seen;
  assign o_ones      = r_ones;

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts ones over WINDOW valid stream bits and
// offers the count downstream through a valid/ready handshake.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int WINDOW = SC_LFSR_PERIOD,
  parameter int CW     = SC_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          result_ready,
  output logic          busy,
  output logic          result_valid,
  output logic [CW-1:0] result,
  output logic [CW-1:0] bits_seen,
  output logic          window_done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

  sc_state_t     r_state;
  sc_state_t     w_next_state;
  logic          w_clear;
  logic          w_enable;
  logic          w_load;
  logic [CW-1:0] w_bits_seen;
  logic [CW-1:0] w_ones;
  logic [CW-1:0] r_result;
  logic          r_window_done;

  sc_ones_counter #(
    .CW(CW)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_bit      (bit_in),
    .o_bits_seen(w_bits_seen),
    .o_ones     (w_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Abort is checked before completion so a cancelled window never publishes.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = COUNT;
          w_clear      = 1'b1;
        end
      end
      COUNT: begin
        if (abort) begin
          w_next_state = IDLE;
          w_clear      = 1'b1;
        end else if (bit_valid) begin
          w_enable = 1'b1;
          if (w_bits_seen == LAST_IDX) begin
            w_load       = 1'b1;
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready) begin
          if (start) begin
            w_next_state = COUNT;
            w_clear      = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The final bit is still in flight when the window closes, so fold it in here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result      <= '0;
      r_window_done <= 1'b0;
    end else begin
      r_window_done <= w_load;
      if (w_load) r_result <= w_ones + CW'(bit_in);
    end
  end

  assign busy         = (r_state == COUNT);
  assign result_valid = (r_state == DONE);
  assign result       = r_result;
  assign bits_seen    = w_bits_seen;
  assign window_done  = r_window_done;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Directed bench for sc_bitstream_decoder: full windows of various patterns,
// gaps, abort, handshake stalls and reset in COUNT and DONE.
module tb_sc_bitstream_decoder;

  localparam int WINDOW = 255;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          bitValid;
  logic          bitIn;
  logic          resultReady;
  logic          busy;
  logic          resultValid;
  logic [CW-1:0] result;
  logic [CW-1:0] bitsSeen;
  logic          windowDone;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sc_bitstream_decoder #(
    .WINDOW(WINDOW),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bitValid),
    .bit_in      (bitIn),
    .result_ready(resultReady),
    .busy        (busy),
    .result_valid(resultValid),
    .result      (result),
    .bits_seen   (bitsSeen),
    .window_done (windowDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic b, input logic r);
    start       = s;
    abort       = a;
    bitValid    = v;
    bitIn       = b;
    resultReady = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"},        busy,        0);
    checkOutput({tag, "_resultValid"}, resultValid, 0);
    checkOutput({tag, "_windowDone"},  windowDone,  0);
    checkOutput({tag, "_result"},      result,      0);
    checkOutput({tag, "_bitsSeen"},    bitsSeen,    0);
  endtask

  // mode 0: all zeros, 1: all ones, 2: alternating starting with 1 at index 0.
  task automatic feedWindow(input int mode, input bit gaps, input int from, input int upTo);
    int   cyc;
    int   seen;
    logic b;
    cyc  = 0;
    seen = from;
    while (seen < upTo) begin
      if (gaps && (cyc % 3 == 2)) begin
        applyStimulus(1'b0, 1'b0, 1'b0, cyc[0], 1'b0);
        checkOutput("gapHold", bitsSeen, seen);
      end else begin
        case (mode)
          0:       b = 1'b0;
          1:       b = 1'b1;
          default: b = (seen % 2 == 0);
        endcase
        applyStimulus(1'b0, 1'b0, 1'b1, b, 1'b0);
        seen++;
      end
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkReset("reset");
    rst = 1'b0;

    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("idleIgnoreBits", bitsSeen, 0);
    checkOutput("idleBusy",       busy,     0);

    // Constant-one window with latency and pulse-width checks
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("startBusy",     busy,     1);
    checkOutput("startBitsSeen", bitsSeen, 0);
    feedWindow(1, 0, 0, WINDOW - 1);
    checkOutput("ones254Seen",  bitsSeen,    254);
    checkOutput("ones254Valid", resultValid, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("onesValid",      resultValid, 1);
    checkOutput("onesResult",     result,      255);
    checkOutput("onesWindowDone", windowDone,  1);
    checkOutput("onesBusy",       busy,        0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("pulseWidth",  windowDone,  0);
    checkOutput("onesHeld",    result,      255);
    checkOutput("onesStillVal", resultValid, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ackValidLow", resultValid, 0);
    checkOutput("ackIdleBusy", busy,        0);
    checkOutput("ackKeepRes",  result,      255);

    // Constant-zero window
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(0, 0, 0, WINDOW);
    checkOutput("zerosValid",  resultValid, 1);
    checkOutput("zerosResult", result,      0);
    applyStimulus(0, 0, 0, 0, 1);

    // Alternating window: ones at even indices 0..254
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(2, 0, 0, WINDOW);
    checkOutput("altResult", result, 128);
    applyStimulus(0, 0, 0, 0, 1);

    // Abort at 100 bits
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(1, 0, 0, 100);
    checkOutput("abortPreSeen", bitsSeen, 100);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("abortBusy",   busy,        0);
    checkOutput("abortSeen",   bitsSeen,    0);
    checkOutput("abortResult", result,      128);
    checkOutput("abortValid",  resultValid, 0);

    // Abort on the completing bit wins
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(1, 0, 0, WINDOW - 1);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("abortLastBusy",   busy,        0);
    checkOutput("abortLastValid",  resultValid, 0);
    checkOutput("abortLastPulse",  windowDone,  0);
    checkOutput("abortLastResult", result,      128);
    checkOutput("abortLastSeen",   bitsSeen,    0);

    // Gapped ones window, with a start in COUNT that must not restart
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(1, 1, 0, 60);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("startInCountSeen", bitsSeen, 61);
    checkOutput("startInCountBusy", busy,     1);
    feedWindow(1, 1, 61, WINDOW);
    checkOutput("gapResult", result,      255);
    checkOutput("gapValid",  resultValid, 1);
    checkOutput("gapPulse",  windowDone,  1);

    // Stall downstream for 20 cycles with the stream still toggling
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (i % 4 == 1), 1'b1, i[0], 1'b0);
      checkOutput("stallResult", result,      255);
      checkOutput("stallValid",  resultValid, 1);
      checkOutput("stallSeen",   bitsSeen,    255);
    end

    // Ready and start together go straight back to COUNT
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("restartBusy",  busy,        1);
    checkOutput("restartSeen",  bitsSeen,    0);
    checkOutput("restartValid", resultValid, 0);

    // Reset in COUNT
    feedWindow(2, 0, 0, 50);
    checkOutput("rstPreSeen", bitsSeen, 50);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 1, 0);
    rst = 1'b0;
    checkReset("rstCount");

    // Reset in DONE discards the pending result
    applyStimulus(1, 0, 0, 0, 0);
    feedWindow(1, 0, 0, WINDOW);
    checkOutput("preRstDoneValid", resultValid, 1);
    checkOutput("preRstDoneRes",   result,      255);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    checkReset("rstDone");
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("postRstValid", resultValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_bitstream_decoder.md
Name: sc_bitstream_decoder

Overview:
- Stochastic-to-binary converter: counts the ones in a stochastic bitstream over a fixed window of WINDOW valid bits and returns the count as an unsigned binary estimate.
- Inverse of the comparator/LFSR stochastic number generator path: the comparator encodes binary into a stream, this block decodes a stream back into binary.
- Sits at the output of a stochastic logic circuit, e.g. driven by a circuit's output_circuit bit, and hands results to downstream logic through a valid/ready handshake.

Parameters:
- WINDOW, 255, number of valid stream bits per conversion; one full period of the 8-bit LFSR; legal range 2..65535.
- CW, 8, width of counters and result; must satisfy 2^CW > WINDOW.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new conversion; honoured per Behaviour.
- abort  input  1  cancel an in-progress conversion.
- bit_valid  input  1  qualifies bit_in for this cycle.
- bit_in  input  1  stochastic stream bit.
- result_ready  input  1  downstream accepts result.
- busy  output  1  high in COUNT.
- result_valid  output  1  high in DONE.
- result  output  CW  ones count of the last completed window.
- bits_seen  output  CW  valid bits consumed in the current window.
- window_done  output  1  single-cycle pulse on entry to DONE; usable to reseed upstream LFSRs.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). All state is registered; no combinational path from inputs to outputs.
- Reset values:
  - state=IDLE
  - busy=0, result_valid=0, window_done=0
  - result=0, bits_seen=0
  - internal ones counter=0
- IDLE:
  - start=1 → COUNT; ones=0, bits_seen=0.
  - bit_valid and bit_in are ignored.
- COUNT:
  - Each cycle with bit_valid=1: bits_seen+=1, ones+=bit_in.
  - Cycles with bit_valid=0 change nothing.
  - The cycle that consumes valid bit number WINDOW (bits_seen==WINDOW-1 and bit_valid=1):
    - result <= ones+bit_in, including the last bit.
    - state → DONE; window_done pulses for the next cycle only.
  - Latency: last valid bit at cycle t → result_valid=1 at t+1.
- abort=1 in COUNT:
  - → IDLE next cycle; ones and bits_seen cleared; result keeps its previous value.
  - Abort takes priority over completion in the same cycle.
  - abort is ignored in IDLE and DONE.
- start while in COUNT is ignored; no restart.
- DONE:
  - result_valid=1; result held stable until accepted.
  - Input bits are ignored; no overflow, no loss of result.
  - result_ready=1 → handshake. Next state is COUNT (counters cleared) if start=1 in the same cycle, else IDLE.
  - result_valid deasserts the cycle after the handshake.
- Width rules:
  - ones never exceeds WINDOW, so no saturation logic is needed.
  - result range 0..WINDOW; estimated probability = result/WINDOW.
- rst asserted in any state: all outputs take their reset values next cycle; a pending result is discarded.

Decomposition:
- Shared package sc_pkg holds:
  - state enum: IDLE, COUNT, DONE
  - constants SC_LFSR_PERIOD=255 and SC_CW=8
- These constants are shared with the stochastic number generator side.
- One natural sub-module: sc_ones_counter, a CW-bit counter pair (bits_seen, ones) with clear and enable.
- The FSM and handshake stay in sc_bitstream_decoder.

Test Plan:
- Constant 1 stream: start, then 255 valid ones → result=255; result_valid 1 cycle after the 255th bit; window_done one cycle wide.
- Constant 0 stream → result=0. Alternating 1,0,… starting with 1 → result=128.
- bit_valid low on every third cycle (gaps), 255 valid ones → result=255 after exactly 255 valid bits; bits_seen never advances on gap cycles.
- abort at bits_seen=100 → IDLE; result keeps its prior value (e.g. 128); a fresh start then decodes a new 255-bit window correctly.
- result_ready held low for 20 cycles with bits still toggling → result stable and result_valid held. Ready plus start in the same cycle → immediately COUNT, bits_seen=0.
- rst asserted mid-COUNT at bits_seen=50 and again in DONE → all outputs 0 next cycle, state IDLE.
